// File: rtl/byte_parity_rx.sv
// Serial byte receiver: start + 8 data (LSB first) + parity + stop, with
// parity/framing errors and all-zero / all-ones status of the received byte.
module byte_parity_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       all_zero,
  output logic       all_ones,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      index;
  logic [7:0]      shift;
  logic            par_bad;
  logic            bit_end;
  logic            half_end;

  // The timer restarts at zero on every sample point, so each bit period is
  // exactly CLKS_PER_BIT cycles and sample points never drift.
  assign bit_end  = (timer == TW'(CLKS_PER_BIT - 1));
  assign half_end = (timer == TW'(HALF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      index      <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      all_zero   <= 1'b0;
      all_ones   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (half_end) begin
            timer <= '0;
            index <= '0;
            if (!rx) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            timer        <= '0;
            shift[index] <= rx;
            if (index == 3'd7) begin
              index <= '0;
              state <= PARITY;
            end else begin
              index <= index + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            timer   <= '0;
            par_bad <= rx ^ (^shift) ^ PARITY_ODD;
            state   <= STOP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            timer      <= '0;
            valid      <= 1'b1;
            data       <= shift;
            parity_err <= par_bad;
            frame_err  <= ~rx;
            all_zero   <= ~|shift;
            all_ones   <= &shift;
            if (rx) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        BREAK: begin
          if (rx) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/byte_parity_rx.md
# byte_parity_rx

Serial byte receiver with parity checking and unary-reduction status flags. It deserialises frames of 1 start bit, 8 data bits (LSB first), 1 parity bit and 1 stop bit from a single-wire input. It presents the byte together with parity, framing, all-zero (NOR-reduction) and all-ones (AND-reduction) flags. It is the receiving end of the byte/parity serial link and the consumer side of the unary-operation test flow.

## Interface
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal values are ≥ 2; HALF = CLKS_PER_BIT/2 (floor).
- PARITY_ODD, 0, 0 selects even parity (parity bit = ^data); 1 selects odd parity (parity bit = ~^data).

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- rx  in  1  serial line, idle high, synchronous to clk (no internal synchroniser).
- data  out  8  last received byte.
- valid  out  1  one-cycle pulse per completed frame.
- parity_err  out  1  parity mismatch on the last frame.
- frame_err  out  1  stop bit sampled 0 on the last frame.
- all_zero  out  1  ~|data of the last frame.
- all_ones  out  1  &data of the last frame.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: if rx==0 on a posedge, go to START and clear the bit-timer. That posedge is frame cycle 0.
- START: at cycle HALF, re-sample rx.
  - rx==0: go to DATA with bit index 0.
  - rx==1 (glitch): return to IDLE; no valid pulse; outputs unchanged.
- DATA: sample rx every CLKS_PER_BIT cycles into shift[index], LSB first. After index 7, go to PARITY.
- PARITY: sample the parity bit. The expected value is ^shift ^ PARITY_ODD.
- STOP: sample rx.
  - All outputs are registered from the completed frame: data, parity_err, frame_err=~rx, all_zero, all_ones.
  - If rx==1, go to IDLE. If rx==0, go to BREAK.
- BREAK: wait until rx==1, then go to IDLE. No start detection occurs while in BREAK.
- valid asserts for every completed frame, including frames with errors. The error flags qualify that frame.
- data and the flags hold their values until the next completed frame. They do not change on a glitch abort or in BREAK.
- The bit-timer must count to CLKS_PER_BIT−1 exactly. There is no drift across the 11 bit periods.

## Timing
- Reset values: data=0x00, valid=0, parity_err=0, frame_err=0, all_zero=0, all_ones=0, busy=0. State is IDLE, timer=0, index=0.
- Reset mid-frame aborts immediately to these values. No partial frame is reported after reset is released.
- Sample points, relative to cycle 0:
  - start check: HALF
  - data bit i: HALF + (i+1)·CLKS_PER_BIT
  - parity: HALF + 9·CLKS_PER_BIT
  - stop: HALF + 10·CLKS_PER_BIT
- Output update and valid: high for exactly one cycle, on the cycle after the stop sample. For CLKS_PER_BIT=4: stop is sampled at cycle 42 and valid is high at cycle 43.
- busy rises on cycle 1 (the posedge after detection) and falls when the state returns to IDLE.
- Back-to-back frames: the state is IDLE on the cycle after the stop sample. A start edge anywhere after that is accepted; no idle gap beyond the stop bit is required.
- rx is a don't-care between sample points.

## Test plan
- CLKS_PER_BIT=4, even parity, send 0xA5 with parity 0 and stop 1 → valid pulse at cycle 43; data=0xA5, parity_err=0, frame_err=0, all_zero=0, all_ones=0.
- Send 0x00 (parity 0), then 0xFF (parity 0) back-to-back → two valid pulses 44 cycles apart. The first gives all_zero=1, all_ones=0; the second gives all_zero=0, all_ones=1.
- Send 0x01 with parity bit 0 → data=0x01, parity_err=1. Repeat with PARITY_ODD=1 → parity_err=0.
- Send 0x3C with stop bit 0 and hold rx low 20 cycles → frame_err=1, valid pulses once, busy stays high until rx rises. A second frame of 0x3C then gives frame_err=0.
- Drive rx low for 1 cycle only → no valid; busy is high for at most HALF cycles; outputs unchanged.
- Assert rst at cycle 20 of a 0x5A frame, release it, then send 0x81 → only one valid, with data=0x81; all outputs read reset values while rst is high.
